// File: rtl/mm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_pkg: shared state encoding and default widths for the job scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package mm_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_WORD_WIDTH = 17;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        NEXT  = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mm_job_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_job_scheduler_if: command, core, host and BRAM signals of the scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
interface mm_job_scheduler_if
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_base_i;
    logic [CNT_WIDTH-1:0]  cmd_count_i;
    logic                  busy_o;
    logic                  job_done_o;
    logic                  error_o;
    logic [CNT_WIDTH-1:0]  mul_index_o;

    logic                  mm_start_o;
    logic                  mm_done_i;
    logic                  mm_en_i;
    logic                  mm_we_i;
    logic [ADDR_WIDTH-1:0] mm_addr_i;
    logic [WORD_WIDTH-1:0] mm_din_i;
    logic [WORD_WIDTH-1:0] mm_dout_o;

    logic                  host_en_i;
    logic                  host_we_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [WORD_WIDTH-1:0] host_din_i;
    logic                  host_gnt_o;
    logic [WORD_WIDTH-1:0] host_dout_o;

    logic                  bram_en_o;
    logic                  bram_we_o;
    logic [ADDR_WIDTH-1:0] bram_addr_o;
    logic [WORD_WIDTH-1:0] bram_din_o;
    logic [WORD_WIDTH-1:0] bram_dout_i;

    // Scheduler side
    modport slave (
        input  cmd_valid_i, cmd_base_i, cmd_count_i,
        output cmd_ready_o, busy_o, job_done_o, error_o, mul_index_o,
        output mm_start_o, mm_dout_o,
        input  mm_done_i, mm_en_i, mm_we_i, mm_addr_i, mm_din_i,
        input  host_en_i, host_we_i, host_addr_i, host_din_i,
        output host_gnt_o, host_dout_o,
        output bram_en_o, bram_we_o, bram_addr_o, bram_din_o,
        input  bram_dout_i
    );

    // Processor / core / BRAM side
    modport master (
        output cmd_valid_i, cmd_base_i, cmd_count_i,
        input  cmd_ready_o, busy_o, job_done_o, error_o, mul_index_o,
        input  mm_start_o, mm_dout_o,
        output mm_done_i, mm_en_i, mm_we_i, mm_addr_i, mm_din_i,
        output host_en_i, host_we_i, host_addr_i, host_din_i,
        input  host_gnt_o, host_dout_o,
        input  bram_en_o, bram_we_o, bram_addr_o, bram_din_o,
        output bram_dout_i
    );
endinterface
`default_nettype wire

// File: rtl/mm_bram_port_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_bram_port_mux: combinational host/core BRAM select with core address relocation
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_bram_port_mux
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  host_gnt,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  mm_en,
    input  logic                  mm_we,
    input  logic [ADDR_WIDTH-1:0] mm_addr,
    input  logic [WORD_WIDTH-1:0] mm_din,
    input  logic                  host_en,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WORD_WIDTH-1:0] host_din,
    input  logic [WORD_WIDTH-1:0] bram_dout,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WORD_WIDTH-1:0] bram_din,
    output logic [WORD_WIDTH-1:0] mm_dout,
    output logic [WORD_WIDTH-1:0] host_dout
);
    always_comb begin
        bram_en   = host_en;
        bram_we   = host_we;
        bram_addr = host_addr;
        bram_din  = host_din;
        if (!host_gnt) begin
            bram_en   = mm_en;
            bram_we   = mm_we;
            // Core addresses are operand-set relative; the sum wraps on overflow
            bram_addr = base + mm_addr;
            bram_din  = mm_din;
        end
    end

    assign mm_dout   = bram_dout;
    assign host_dout = bram_dout;
endmodule
`default_nettype wire

// File: rtl/mm_job_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_job_scheduler: runs N back-to-back Montgomery multiplications and owns the BRAM port
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_job_scheduler
    import mm_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int STRIDE     = 64,
    parameter int TIMEOUT    = 4095
) (
    input  logic              clock_i,
    input  logic              reset_i,
    mm_job_scheduler_if.slave bus
);
    localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  mul_index;
    logic [WD_WIDTH-1:0]   wd_count;
    logic                  done_q;
    logic                  error;
    logic                  job_done;
    logic                  done_edge;
    logic                  wd_expired;

    assign done_edge  = bus.mm_done_i & ~done_q;
    assign wd_expired = (TIMEOUT != 0) && (wd_count == WD_WIDTH'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.cmd_valid_i)
                         state_next = (bus.cmd_count_i == '0) ? FIN : START;
            START:   state_next = RUN;
            // A completed multiplication wins over a same-cycle watchdog expiry
            RUN:     if (done_edge)
                         state_next = (remaining > CNT_WIDTH'(1)) ? NEXT : FIN;
                     else if (wd_expired)
                         state_next = FIN;
            NEXT:    state_next = START;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= IDLE;
            base      <= '0;
            remaining <= '0;
            mul_index <= '0;
            wd_count  <= '0;
            done_q    <= 1'b0;
            error     <= 1'b0;
            job_done  <= 1'b0;
        end else begin
            state    <= state_next;
            done_q   <= bus.mm_done_i;
            job_done <= (state == FIN);
            case (state)
                IDLE: if (bus.cmd_valid_i) begin
                    base      <= bus.cmd_base_i;
                    remaining <= bus.cmd_count_i;
                    mul_index <= '0;
                    error     <= 1'b0;
                end
                START: wd_count <= '0;
                RUN: begin
                    wd_count <= wd_count + 1'b1;
                    if (done_edge)
                        mul_index <= mul_index + CNT_WIDTH'(1);
                    else if (wd_expired)
                        error <= 1'b1;
                end
                NEXT: begin
                    base      <= base + ADDR_WIDTH'(STRIDE);
                    remaining <= remaining - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = (state == IDLE);
    assign bus.host_gnt_o  = (state == IDLE);
    assign bus.busy_o      = (state != IDLE);
    assign bus.mm_start_o  = (state == START);
    assign bus.job_done_o  = job_done;
    assign bus.error_o     = error;
    assign bus.mul_index_o = mul_index;

    mm_bram_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_port_mux (
        .host_gnt  (state == IDLE),
        .base      (base),
        .mm_en     (bus.mm_en_i),
        .mm_we     (bus.mm_we_i),
        .mm_addr   (bus.mm_addr_i),
        .mm_din    (bus.mm_din_i),
        .host_en   (bus.host_en_i),
        .host_we   (bus.host_we_i),
        .host_addr (bus.host_addr_i),
        .host_din  (bus.host_din_i),
        .bram_dout (bus.bram_dout_i),
        .bram_en   (bus.bram_en_o),
        .bram_we   (bus.bram_we_o),
        .bram_addr (bus.bram_addr_o),
        .bram_din  (bus.bram_din_o),
        .mm_dout   (bus.mm_dout_o),
        .host_dout (bus.host_dout_o)
    );
endmodule
`default_nettype wire

// File: tb/tb_mm_job_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_mm_job_scheduler: scoreboard bench for the job scheduler (main and short-watchdog instances)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mm_job_scheduler;
    import mm_pkg::*;

    localparam int AW = 10;
    localparam int WW = 17;
    localparam int CW = 8;

    typedef struct {
        int mul;
        bit err;
        bit rel_edge;
        int cyc;
        int starts;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mm_job_scheduler_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();
    mm_job_scheduler_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) wbus ();

    mm_job_scheduler #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW),
                       .STRIDE(64), .TIMEOUT(4095))
        dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    mm_job_scheduler #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW),
                       .STRIDE(64), .TIMEOUT(50))
        dut_wd (.clock_i(clk), .reset_i(rst), .bus(wbus));

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   edge_cyc = 0;
    int   start_cnt = 0;
    int   core_delay = 0;
    logic prev_done = 1'b0;
    exp_t jq[$];
    exp_t wq[$];
    int   aq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Core model: one-cycle done pulse core_delay cycles after each start
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mm_start_o && core_delay > 0) begin
                repeat (core_delay) @(posedge clk);
                #1 bus.mm_done_i = 1'b1;
                @(posedge clk);
                #1 bus.mm_done_i = 1'b0;
            end
        end
    end

    // Monitor, main instance
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mm_done_i && !prev_done) edge_cyc = cyc;
            if (bus.mm_start_o) begin
                start_cnt++;
                if (aq.size() == 0) flag("unexpected_mm_start");
                else chk("start_bram_addr", 32'(bus.bram_addr_o), 32'(aq.pop_front()));
            end
            if (bus.job_done_o) begin
                if (jq.size() == 0) flag("unexpected_job_done");
                else begin
                    exp_t e;
                    e = jq.pop_front();
                    chk("job_mul_index", 32'(bus.mul_index_o), 32'(e.mul));
                    chk("job_error", 32'(bus.error_o), 32'(e.err));
                    chk("job_done_cycle", cyc, e.rel_edge ? edge_cyc + 2 : e.cyc);
                    chk("job_start_pulses", start_cnt, e.starts);
                end
                start_cnt = 0;
            end
        end
        prev_done = bus.mm_done_i;
    end

    // Monitor, watchdog instance
    always @(negedge clk) begin
        if (!rst && wbus.job_done_o) begin
            if (wq.size() == 0) flag("wd_unexpected_job_done");
            else begin
                exp_t e;
                e = wq.pop_front();
                chk("wd_mul_index", 32'(wbus.mul_index_o), 32'(e.mul));
                chk("wd_error", 32'(wbus.error_o), 32'(e.err));
                chk("wd_job_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_job(input int b, input int n, input bit push, input int mul,
                            input bit err, input bit rel, input int off, input int starts);
        exp_t e;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_base_i  = AW'(b);
        bus.cmd_count_i = CW'(n);
        @(negedge clk);
        chk("cmd_ready_at_accept", 32'(bus.cmd_ready_o), 32'd1);
        e = '{mul, err, rel, cyc + off, starts};
        if (push) jq.push_back(e);
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic send_wd_job(input int n, input int mul, input bit err, input int off);
        exp_t e;
        @(posedge clk);
        #1;
        wbus.cmd_valid_i = 1'b1;
        wbus.cmd_count_i = CW'(n);
        @(negedge clk);
        e = '{mul, err, 1'b0, cyc + off, 0};
        wq.push_back(e);
        @(posedge clk);
        #1 wbus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_q(input int which, input int budget);
        int k = 0;
        while (((which == 0) ? jq.size() : wq.size()) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (((which == 0) ? jq.size() : wq.size()) != 0) begin
            flag("job_done_wait_expired");
            if (which == 0) jq.delete();
            else wq.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid_i = 0; bus.cmd_base_i = 0; bus.cmd_count_i = 0;
        bus.mm_done_i = 0; bus.mm_en_i = 1; bus.mm_we_i = 0;
        bus.mm_addr_i = AW'(2); bus.mm_din_i = 0;
        bus.host_en_i = 0; bus.host_we_i = 0; bus.host_addr_i = 0; bus.host_din_i = 0;
        bus.bram_dout_i = 0;
        wbus.cmd_valid_i = 0; wbus.cmd_base_i = 0; wbus.cmd_count_i = 0;
        wbus.mm_done_i = 0; wbus.mm_en_i = 0; wbus.mm_we_i = 0;
        wbus.mm_addr_i = 0; wbus.mm_din_i = 0;
        wbus.host_en_i = 0; wbus.host_we_i = 0; wbus.host_addr_i = 0; wbus.host_din_i = 0;
        wbus.bram_dout_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_host_gnt", 32'(bus.host_gnt_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_job_done", 32'(bus.job_done_o), 32'd0);
        chk("rst_error", 32'(bus.error_o), 32'd0);
        chk("rst_mul_index", 32'(bus.mul_index_o), 32'd0);
        chk("rst_mm_start", 32'(bus.mm_start_o), 32'd0);
        chk("rst_bram_en", 32'(bus.bram_en_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Host write while idle, plus read-data forwarding
        bus.host_en_i = 1; bus.host_we_i = 1; bus.host_addr_i = AW'(5);
        bus.host_din_i = WW'(17'h1ABCD); bus.bram_dout_i = WW'(17'h0F0F0);
        @(negedge clk);
        chk("host_gnt_idle", 32'(bus.host_gnt_o), 32'd1);
        chk("host_bram_en", 32'(bus.bram_en_o), 32'd1);
        chk("host_bram_we", 32'(bus.bram_we_o), 32'd1);
        chk("host_bram_addr", 32'(bus.bram_addr_o), 32'd5);
        chk("host_bram_din", 32'(bus.bram_din_o), 32'h1ABCD);
        chk("host_dout", 32'(bus.host_dout_o), 32'h0F0F0);
        chk("mm_dout", 32'(bus.mm_dout_o), 32'h0F0F0);
        @(posedge clk);
        #1 bus.host_en_i = 0; bus.host_we_i = 0;

        // Single multiplication, core done 100 cycles after start
        core_delay = 100;
        aq.push_back(32'h002);
        send_job(0, 1, 1'b1, 1, 1'b0, 1'b1, 0, 1);
        wait_q(0, 300);

        // Three multiplications with base wrap: 0x3F2, 0x032, 0x072
        core_delay = 20;
        aq.push_back(32'h3F2); aq.push_back(32'h032); aq.push_back(32'h072);
        send_job(32'h3F0, 3, 1'b1, 3, 1'b0, 1'b1, 0, 3);
        wait_q(0, 300);

        // Empty job: no start, done two cycles after accept, busy for one cycle
        send_job(32'h100, 0, 1'b1, 0, 1'b0, 1'b0, 2, 0);
        @(negedge clk);
        chk("count0_busy_fin", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        chk("count0_busy_after", 32'(bus.busy_o), 32'd0);
        wait_q(0, 20);

        // Watchdog instance: core never finishes
        send_wd_job(2, 0, 1'b1, 53);
        wait_q(1, 200);
        repeat (3) @(negedge clk);
        chk("wd_error_sticky", 32'(wbus.error_o), 32'd1);
        send_wd_job(0, 0, 1'b0, 2);
        @(negedge clk);
        chk("wd_error_cleared", 32'(wbus.error_o), 32'd0);
        wait_q(1, 20);

        // Host request during RUN is ignored; reset mid-job returns to IDLE silently
        core_delay = 0;
        aq.push_back(32'h202);
        send_job(32'h200, 2, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        bus.host_en_i = 1; bus.host_we_i = 1; bus.host_addr_i = AW'(9);
        bus.host_din_i = WW'(17'h00155);
        bus.mm_we_i = 1; bus.mm_din_i = WW'(17'h0AAAA);
        @(negedge clk);
        chk("run_busy", 32'(bus.busy_o), 32'd1);
        chk("run_host_gnt", 32'(bus.host_gnt_o), 32'd0);
        chk("run_bram_addr", 32'(bus.bram_addr_o), 32'h202);
        chk("run_bram_din", 32'(bus.bram_din_o), 32'h0AAAA);
        chk("run_bram_we", 32'(bus.bram_we_o), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start_cnt = 0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_mid_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_mid_host_gnt", 32'(bus.host_gnt_o), 32'd1);
        chk("rst_mid_bram_addr", 32'(bus.bram_addr_o), 32'd9);
        chk("rst_mid_bram_din", 32'(bus.bram_din_o), 32'h00155);
        bus.host_en_i = 0; bus.host_we_i = 0; bus.mm_we_i = 0;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_start_left", aq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
